// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with credit-limited tag queue and instruction buffer
//
// Purpose:
//   Issues instruction-memory reads for PCs offered by the PC generator. Each
//   granted read is tracked in an in-order tag queue. Each returned word is
//   paired with its PC and misaligned flag and placed in the instruction
//   buffer. A flush discards buffered entries and outstanding reads; reads
//   already in flight are counted in 'drop' and their responses are thrown
//   away when they return.
//
// Ports:
//   clk             rising-edge clock
//   res             asynchronous active-low reset
//   pc_in/pc_valid  fetch address offer; pc_ready = offer accepted (granted)
//   mem_req/mem_addr/mem_gnt         read request channel (word-aligned address)
//   mem_rvalid/mem_rdata             in-order read responses
//   flush           redirect: discard buffered and in-flight fetches
//   inst_valid/inst/inst_pc/inst_misaligned/inst_ready  head of instruction buffer
module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_misaligned,
  input  logic        inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   tag_pc   [DEPTH];
  logic          tag_mis  [DEPTH];
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;

  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic          buf_mis  [DEPTH];
  logic [PW-1:0] buf_wr;
  logic [PW-1:0] buf_rd;

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW+1:0] used;
  logic          credit;
  logic          grant;
  logic          rsp_live;
  logic          rsp_drop;
  logic          wr;
  logic          pop;
  logic [CW-1:0] pend;
  logic [CW-1:0] flush_drop;

  // Reads still owed by memory for dropped fetches occupy credit too, so a
  // new fetch can never be paired with a stale response.
  assign used     = (CW+2)'(outstanding) + (CW+2)'(count) + (CW+2)'(drop);
  assign credit   = used < (CW+2)'(DEPTH);
  assign mem_req  = res && pc_valid && credit && !flush;
  assign mem_addr = {pc_in[31:2], 2'b00};
  assign grant    = mem_req && mem_gnt;
  assign pc_ready = grant;

  // Responses retire dropped reads first, since those were issued earlier.
  assign rsp_drop = mem_rvalid && (drop != '0);
  assign rsp_live = mem_rvalid && (drop == '0) && (outstanding != '0);
  assign wr       = rsp_live && !flush;

  assign inst_valid      = (count != '0);
  assign inst            = buf_inst[buf_rd];
  assign inst_pc         = buf_pc[buf_rd];
  assign inst_misaligned = buf_mis[buf_rd];
  assign pop             = inst_valid && inst_ready && !flush;

  // Everything still owed by memory becomes drop; a response arriving in the
  // flush cycle itself retires one of them.
  assign pend       = drop + outstanding;
  assign flush_drop = (mem_rvalid && (pend != '0)) ? pend - CW'(1) : pend;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc[i]   <= '0;
        tag_mis[i]  <= 1'b0;
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
        buf_mis[i]  <= 1'b0;
      end
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (flush) begin
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= flush_drop;
    end else begin
      if (grant) begin
        tag_pc[tag_wr]  <= pc_in;
        tag_mis[tag_wr] <= |pc_in[1:0];
        tag_wr          <= tag_wr + PW'(1);
      end
      if (wr) begin
        buf_inst[buf_wr] <= mem_rdata;
        buf_pc[buf_wr]   <= tag_pc[tag_rd];
        buf_mis[buf_wr]  <= tag_mis[tag_rd];
        buf_wr           <= buf_wr + PW'(1);
        tag_rd           <= tag_rd + PW'(1);
      end
      if (pop) begin
        buf_rd <= buf_rd + PW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({grant, rsp_live})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch (DEPTH=2)
module tb_ifetch;

  logic        clk;
  logic        res;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misaligned;
  logic        inst_ready;

  int total = 0;
  int bad   = 0;

  ifetch #(.DEPTH(2)) dut (
    .clk             (clk),
    .res             (res),
    .pc_in           (pc_in),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_misaligned (inst_misaligned),
    .inst_ready      (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0; pc_valid = 1'b1; pc_in = 32'h0; mem_gnt = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0; inst_ready = 1'b0;
    #2;
    total++;
    if ({inst_valid, mem_req, pc_ready} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {inst_valid, mem_req, pc_ready});
    end
    total++;
    if ({inst, inst_pc, inst_misaligned} !== 65'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%b exp=0/0/0", inst, inst_pc, inst_misaligned);
    end
    pc_valid = 1'b0; mem_gnt = 1'b0;
    tick(); tick();
    res = 1'b1;
    #1;
    total++;
    if ({inst_valid, mem_req} !== 2'b00) begin
      bad++; $display("FAIL reset_release got=%b exp=00", {inst_valid, mem_req});
    end
  endtask

  task automatic test_back_to_back();
    tick(); pc_valid = 1'b1; pc_in = 32'h0; mem_gnt = 1'b1; inst_ready = 1'b1; #1;
    total++;
    if ({mem_req, pc_ready, mem_addr} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL b2b_req0 got=%b%b/%h exp=11/00000000", mem_req, pc_ready, mem_addr);
    end
    tick(); pc_in = 32'h4; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000; #1;
    total++;
    if ({pc_ready, mem_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
      bad++; $display("FAIL b2b_req4 got=%b/%h/%b exp=1/00000004/0", pc_ready, mem_addr, inst_valid);
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hA000_0004; #1;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, 32'hA000_0000}) begin
      bad++; $display("FAIL b2b_inst0 got=%b/%h/%h exp=1/00000000/a0000000", inst_valid, inst_pc, inst);
    end
    tick(); mem_rvalid = 1'b0; #1;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h4, 32'hA000_0004}) begin
      bad++; $display("FAIL b2b_inst4 got=%b/%h/%h exp=1/00000004/a0000004", inst_valid, inst_pc, inst);
    end
    tick(); #1;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_empty got=%b exp=0", inst_valid);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_credit();
    tick(); pc_valid = 1'b1; pc_in = 32'h10; mem_gnt = 1'b1; inst_ready = 1'b0; #1;
    total++;
    if (pc_ready !== 1'b1) begin bad++; $display("FAIL credit_g0 got=%b exp=1", pc_ready); end
    tick(); pc_in = 32'h14; #1;
    total++;
    if (pc_ready !== 1'b1) begin bad++; $display("FAIL credit_g1 got=%b exp=1", pc_ready); end
    tick(); pc_in = 32'h18; #1;
    total++;
    if ({mem_req, pc_ready} !== 2'b00) begin
      bad++; $display("FAIL credit_full got=%b exp=00", {mem_req, pc_ready});
    end
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hB000_0010; #1;
    total++;
    if (pc_ready !== 1'b0) begin bad++; $display("FAIL credit_out2 got=%b exp=0", pc_ready); end
    tick(); mem_rdata = 32'hB000_0014; #1;
    total++;
    if ({pc_ready, inst_valid, inst_pc} !== {2'b01, 32'h10}) begin
      bad++; $display("FAIL credit_mix got=%b%b/%h exp=01/00000010", pc_ready, inst_valid, inst_pc);
    end
    tick(); mem_rvalid = 1'b0; inst_ready = 1'b1; #1;
    total++;
    if (pc_ready !== 1'b0) begin bad++; $display("FAIL credit_buf2 got=%b exp=0", pc_ready); end
    tick(); #1;
    total++;
    if ({pc_ready, mem_addr, inst_pc, inst} !== {1'b1, 32'h18, 32'h14, 32'hB000_0014}) begin
      bad++; $display("FAIL credit_reopen got=%b/%h/%h/%h exp=1/00000018/00000014/b0000014",
                      pc_ready, mem_addr, inst_pc, inst);
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB000_0018; #1;
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL credit_nobypass got=%b exp=0", inst_valid); end
    tick(); mem_rvalid = 1'b0; #1;
    total++;
    if ({inst_valid, inst_pc, inst, inst_misaligned} !== {1'b1, 32'h18, 32'hB000_0018, 1'b0}) begin
      bad++; $display("FAIL credit_third got=%b/%h/%h/%b exp=1/00000018/b0000018/0",
                      inst_valid, inst_pc, inst, inst_misaligned);
    end
    tick(); #1;
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL credit_empty got=%b exp=0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_flush();
    tick(); pc_valid = 1'b1; pc_in = 32'h8; mem_gnt = 1'b1; inst_ready = 1'b1; #1;
    tick(); pc_in = 32'hC; #1;
    tick(); pc_in = 32'h100; flush = 1'b1; #1;
    total++;
    if ({mem_req, pc_ready} !== 2'b00) begin
      bad++; $display("FAIL flush_req got=%b exp=00", {mem_req, pc_ready});
    end
    tick(); flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0008; #1;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_drop2 got=%b exp=0", mem_req); end
    tick(); mem_rdata = 32'hDEAD_000C; #1;
    total++;
    if ({pc_ready, mem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      bad++; $display("FAIL flush_newreq got=%b/%h/%b exp=1/00000100/0", pc_ready, mem_addr, inst_valid);
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_stale got=%b exp=0", inst_valid); end
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hC000_0100; #1;
    tick(); mem_rvalid = 1'b0; #1;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, 32'hC000_0100}) begin
      bad++; $display("FAIL flush_new got=%b/%h/%h exp=1/00000100/c0000100", inst_valid, inst_pc, inst);
    end
    tick(); #1;
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_flush_buffered();
    tick(); pc_valid = 1'b1; pc_in = 32'h40; mem_gnt = 1'b1; inst_ready = 1'b0; #1;
    tick(); pc_in = 32'h44; mem_rvalid = 1'b1; mem_rdata = 32'hE000_0040; #1;
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hE000_0044;
    flush = 1'b1; inst_ready = 1'b1; #1;
    total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h40}) begin
      bad++; $display("FAIL fbuf_pre got=%b/%h exp=1/00000040", inst_valid, inst_pc);
    end
    tick(); flush = 1'b0; mem_rvalid = 1'b0; pc_valid = 1'b1; pc_in = 32'h48; mem_gnt = 1'b1; #1;
    total++;
    if ({inst_valid, pc_ready} !== 2'b01) begin
      bad++; $display("FAIL fbuf_post got=%b exp=01", {inst_valid, pc_ready});
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hE000_0048; #1;
    tick(); mem_rvalid = 1'b0; #1;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h48, 32'hE000_0048}) begin
      bad++; $display("FAIL fbuf_new got=%b/%h/%h exp=1/00000048/e0000048", inst_valid, inst_pc, inst);
    end
    tick(); #1;
    inst_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    tick(); pc_valid = 1'b1; pc_in = 32'h6; mem_gnt = 1'b1; inst_ready = 1'b1; #1;
    total++;
    if ({pc_ready, mem_addr} !== {1'b1, 32'h4}) begin
      bad++; $display("FAIL mis_addr got=%b/%h exp=1/00000004", pc_ready, mem_addr);
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5151_0006; #1;
    tick(); mem_rvalid = 1'b0; #1;
    total++;
    if ({inst_valid, inst_misaligned, inst_pc, inst} !== {2'b11, 32'h6, 32'h5151_0006}) begin
      bad++; $display("FAIL mis_inst got=%b%b/%h/%h exp=11/00000006/51510006",
                      inst_valid, inst_misaligned, inst_pc, inst);
    end
    tick(); #1;
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(); pc_valid = 1'b1; pc_in = 32'h20; mem_gnt = 1'b1; inst_ready = 1'b0; #1;
    tick(); pc_in = 32'h24; mem_rvalid = 1'b1; mem_rdata = 32'h7000_0020; #1;
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h7000_0024; #1;
    tick(); mem_rvalid = 1'b0; pc_valid = 1'b1; pc_in = 32'h0; mem_gnt = 1'b1; #1;
    total++;
    if ({inst_valid, inst_pc, mem_req} !== {1'b1, 32'h20, 1'b0}) begin
      bad++; $display("FAIL rmid_full got=%b/%h/%b exp=1/00000020/0", inst_valid, inst_pc, mem_req);
    end
    res = 1'b0; #1;
    total++;
    if ({inst_valid, mem_req, pc_ready, inst_pc, inst} !== 67'h0) begin
      bad++; $display("FAIL rmid_async got=%b%b%b/%h/%h exp=000/00000000/00000000",
                      inst_valid, mem_req, pc_ready, inst_pc, inst);
    end
    tick(); res = 1'b1; #1;
    total++;
    if ({pc_ready, mem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL rmid_refetch got=%b/%h/%b exp=1/00000000/0", pc_ready, mem_addr, inst_valid);
    end
    tick(); pc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7000_0000; #1;
    tick(); mem_rvalid = 1'b0; inst_ready = 1'b1; #1;
    total++;
    if ({inst_valid, inst_pc, inst, inst_misaligned} !== {1'b1, 32'h0, 32'h7000_0000, 1'b0}) begin
      bad++; $display("FAIL rmid_inst got=%b/%h/%h/%b exp=1/00000000/70000000/0",
                      inst_valid, inst_pc, inst, inst_misaligned);
    end
    tick(); #1;
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL rmid_empty got=%b exp=0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_credit();
    test_flush();
    test_flush_buffered();
    test_misaligned();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
